// File: rtl/pipelined_decode_stage.sv
// -----------------------------------------------------------------------------
// pipelined_decode_stage
//
// Registered decode stage sitting between instruction fetch and register-read/EX.
// An instruction word is accepted over a valid/ready handshake, its 4-bit opcode
// is decoded into a 10-bit control rod, and the rod plus the three register
// fields are held in an output register until EX takes them. The stage inserts
// stall cycles after a multi-cycle MUL issues and a single bubble for a load-use
// hazard, and it can be flushed by a taken branch or a resolved jump.
//
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN
//   defined   : undefined opcodes decode to an all-zero rod (they issue as a NOP)
//               and raise illegal_op while they are presented to EX.
//   undefined : undefined opcodes fall through the opcode-class decode rules and
//               illegal_op is tied low.
//
// Parameters
//   REG_ADDR_W   width of each register-address field
//   MUL_LATENCY  EX cycles a MUL occupies (>=1); MUL_LATENCY-1 dead cycles follow
//                the MUL issue cycle
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   in_valid   in   instruction word valid
//   in_ready   out  stage can accept an instruction this cycle
//   instr      in   {opcode[3:0], rd, rs1, rs2}, rs2 at the LSBs
//   flush      in   kill the held instruction and any MUL stall
//   out_valid  out  ctrl and register fields valid to EX
//   out_ready  in   EX accepts this cycle
//   ctrl       out  control rod: [2:0] ALU op, [3] IsBranch, [4] IsLoad,
//                   [5] IsMemWrite, [6] IsRegWrite, [7] JMP, [8] reads rs2,
//                   [9] reads rs1
//   out_rd     out  destination register field
//   out_rs1    out  source register 1 field
//   out_rs2    out  source register 2 field
//   busy       out  stage is in a MUL stall
//   illegal_op out  held undefined opcode is being presented (trap build only)
// -----------------------------------------------------------------------------
module pipelined_decode_stage #(
    parameter int REG_ADDR_W  = 4,
    parameter int MUL_LATENCY = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4+3*REG_ADDR_W-1:0]  instr,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [9:0]                 ctrl,
    output logic [REG_ADDR_W-1:0]      out_rd,
    output logic [REG_ADDR_W-1:0]      out_rs1,
    output logic [REG_ADDR_W-1:0]      out_rs2,
    output logic                       busy,
    output logic                       illegal_op
);

    localparam int INSTR_W = 4 + 3*REG_ADDR_W;
    localparam int CNT_W   = $clog2(MUL_LATENCY) + 1;

    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_LD  = 4'b1101;

    typedef enum logic [0:0] {
        S_RUN,
        S_MUL_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   hold_valid_q;
    logic [3:0]             op_q;
    logic [9:0]             ctrl_q;
    logic [REG_ADDR_W-1:0]  rd_q, rs1_q, rs2_q;

    logic                   ld_flag_q;
    logic [REG_ADDR_W-1:0]  ld_rd_q;

    logic                   run;
    logic                   hazard;
    logic                   issue;
    logic                   transfer;

    logic [3:0]             in_op;
    logic [REG_ADDR_W-1:0]  in_rd, in_rs1, in_rs2;

    assign in_op  = instr[INSTR_W-1 -: 4];
    assign in_rd  = instr[3*REG_ADDR_W-1 -: REG_ADDR_W];
    assign in_rs1 = instr[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign in_rs2 = instr[REG_ADDR_W-1:0];

`ifdef DECODE_ILLEGAL_TRAP_EN
    // Opcodes with no architectural meaning; they travel down the pipe as a NOP.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op == 4'b0000) || (op == 4'b0101) || (op == 4'b0111) ||
               (op == 4'b1001) || (op == 4'b1110);
    endfunction
`endif

    // Opcode-class decode. The defined opcodes all fall out of these three
    // class rules, so a single rule set covers both defined and undefined
    // encodings; the trap build only overrides the undefined ones.
    function automatic logic [9:0] decode_op(input logic [3:0] op);
        logic [9:0] c;
        c = '0;
        if (!op[3]) begin
            // ALU class: op[2:0] is the ALU op, always writes rd and reads rs1;
            // only the op[1:0]==11 encoding (INC) skips rs2.
            c[2:0] = op[2:0];
            c[6]   = 1'b1;
            c[9]   = 1'b1;
            c[8]   = ~(op[1] & op[0]);
        end else if (op[1:0] == 2'b11) begin
            // Control-flow class: op[2] selects JMP over BEQ.
            c = op[2] ? 10'h080 : 10'h208;
        end else begin
            // Memory/misc class: op[2:0] maps straight onto RegWrite/MemWrite/Load.
            c[6:4] = op[2:0];
            c[9]   = op[1];
        end
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (is_illegal(op)) begin
            c = '0;
        end
`endif
        return c;
    endfunction

    // A bubble is raised only in the cycle right after a LD issued, and only
    // when the held instruction actually reads the loaded register. ld_flag
    // drops on the next edge, so the same instruction can never bubble twice.
    assign hazard = ld_flag_q &
                    ((ctrl_q[9] & (rs1_q == ld_rd_q)) |
                     (ctrl_q[8] & (rs2_q == ld_rd_q)));

    assign run       = (state_q == S_RUN);
    assign out_valid = !rst & hold_valid_q & run & !hazard;
    assign issue     = out_valid & out_ready;
    assign in_ready  = !rst & run & !flush & (!hold_valid_q | issue);
    assign transfer  = in_valid & in_ready;
    assign busy      = !rst & !run;

    // Outputs are forced to zero while reset is held; otherwise they follow
    // the holding register, which only changes on a transfer in, so they stay
    // stable for as long as EX back-pressures.
    assign ctrl    = rst ? '0 : ctrl_q;
    assign out_rd  = rst ? '0 : rd_q;
    assign out_rs1 = rst ? '0 : rs1_q;
    assign out_rs2 = rst ? '0 : rs2_q;

    // State and stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. Flush abandons any MUL stall. A MUL issue loads the
    // counter with MUL_LATENCY-2 so that the wait state lasts MUL_LATENCY-1
    // cycles including the cycle where the counter reads zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = S_RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (issue && (op_q == OP_MUL) && (MUL_LATENCY > 1)) begin
                        state_d = S_MUL_WAIT;
                        cnt_d   = CNT_W'(MUL_LATENCY - 2);
                    end
                end
                S_MUL_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Holding register. A transfer in and an issue in the same cycle replace
    // the held instruction; an issue alone empties the hold. Flush empties it
    // even if the held instruction is issuing in the same cycle (EX still
    // received that one).
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            op_q         <= '0;
            ctrl_q       <= '0;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
        end else if (flush) begin
            hold_valid_q <= 1'b0;
        end else if (transfer) begin
            hold_valid_q <= 1'b1;
            op_q         <= in_op;
            ctrl_q       <= decode_op(in_op);
            rd_q         <= in_rd;
            rs1_q        <= in_rs1;
            rs2_q        <= in_rs2;
        end else if (issue) begin
            hold_valid_q <= 1'b0;
        end
    end

    // Load-use tracker: remembers the destination of a LD for exactly one
    // cycle after it issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_flag_q <= 1'b0;
            ld_rd_q   <= '0;
        end else if (flush) begin
            ld_flag_q <= 1'b0;
        end else if (issue && (op_q == OP_LD)) begin
            ld_flag_q <= 1'b1;
            ld_rd_q   <= rd_q;
        end else begin
            ld_flag_q <= 1'b0;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Remembers whether the held instruction came from an undefined opcode.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (!flush && transfer) begin
            illegal_q <= is_illegal(in_op);
        end
    end

    assign illegal_op = illegal_q & out_valid;
`else
    assign illegal_op = 1'b0;
`endif

endmodule
